// File: rtl/du_dmem_rx.sv
// du_dmem_rx: loads data memory from UART frames of address and data, LSB byte first,
// acknowledging each write with ACK_BYTE; an all-ones address ends the session.
module du_dmem_rx #(
    parameter int                      NB_DATA      = 32,
    parameter int                      NB_UART_DATA = 8,
    parameter logic [NB_UART_DATA-1:0] ACK_BYTE     = 8'hA5
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_rx_done,
    input  logic [NB_UART_DATA-1:0] i_rx_data,
    input  logic                    i_tx_done,
    output logic                    o_done,
    output logic                    o_dmem_wr,
    output logic [1:0]              o_dmem_wsize,
    output logic [NB_DATA-1:0]      o_dmem_waddr,
    output logic [NB_DATA-1:0]      o_dmem_wdata,
    output logic                    o_rd,
    output logic                    o_wr,
    output logic                    o_tx_start,
    output logic [NB_UART_DATA-1:0] o_wdata
);
    localparam logic [2:0] NB_BYTES = 3'(NB_DATA / NB_UART_DATA);

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, WRITE, ACK} state_t;

    state_t             state, state_next;
    logic [2:0]         cnt, cnt_next;
    logic [NB_DATA-1:0] addr, addr_next, data, data_next;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            addr  <= addr_next;
            data  <= data_next;
        end
    end

    // In ACK the counter doubles as a flag: 0 = push the ACK byte, 1 = wait for Tx.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        addr_next    = addr;
        data_next    = data;
        o_done       = 1'b0;
        o_dmem_wr    = 1'b0;
        o_dmem_wsize = 2'b00;
        o_dmem_waddr = '0;
        o_dmem_wdata = '0;
        o_rd         = 1'b0;
        o_wr         = 1'b0;
        o_tx_start   = 1'b0;
        o_wdata      = '0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RX_ADDR;
                    cnt_next   = '0;
                end
            end
            RX_ADDR: begin
                if (cnt < NB_BYTES) begin
                    if (i_rx_done) begin
                        o_rd      = 1'b1;
                        addr_next = {i_rx_data, addr[NB_DATA-1:NB_UART_DATA]};
                        cnt_next  = cnt + 3'd1;
                    end
                end else begin
                    cnt_next   = '0;
                    o_done     = &addr;
                    state_next = (&addr) ? IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt < NB_BYTES) begin
                    if (i_rx_done) begin
                        o_rd      = 1'b1;
                        data_next = {i_rx_data, data[NB_DATA-1:NB_UART_DATA]};
                        cnt_next  = cnt + 3'd1;
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                o_dmem_wr    = 1'b1;
                o_dmem_wsize = 2'b11;
                o_dmem_waddr = addr;
                o_dmem_wdata = data;
                state_next   = ACK;
            end
            ACK: begin
                if (cnt == 3'd0) begin
                    o_wr       = 1'b1;
                    o_tx_start = 1'b1;
                    o_wdata    = ACK_BYTE;
                    cnt_next   = 3'd1;
                end else if (i_tx_done) begin
                    cnt_next   = '0;
                    state_next = RX_ADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_du_dmem_rx.sv
// tb_du_dmem_rx: directed frames into du_dmem_rx, checked against hand-computed writes/ACKs.
module tb_du_dmem_rx;
    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_tx_done = 1'b0;
    logic        o_done, o_dmem_wr, o_rd, o_wr, o_tx_start;
    logic [1:0]  o_dmem_wsize;
    logic [31:0] o_dmem_waddr, o_dmem_wdata;
    logic [7:0]  o_wdata;

    int vectors = 0, errs = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, n_tx = 0, n_done = 0, bad = 0;
    int tx_delay = 2, gseq = 0, last_tx_cyc = 0, last_pop_cyc = 0;
    logic [31:0] wa [16];
    logic [31:0] wd [16];
    logic [1:0]  last_wsize = '0;
    logic [7:0]  last_tx_byte = '0;

    du_dmem_rx dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_rx_done(i_rx_done),
        .i_rx_data(i_rx_data), .i_tx_done(i_tx_done), .o_done(o_done),
        .o_dmem_wr(o_dmem_wr), .o_dmem_wsize(o_dmem_wsize), .o_dmem_waddr(o_dmem_waddr),
        .o_dmem_wdata(o_dmem_wdata), .o_rd(o_rd), .o_wr(o_wr), .o_tx_start(o_tx_start),
        .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_rd) n_rd <= n_rd + 1;
        if (o_done) n_done <= n_done + 1;
        if (o_dmem_wr) begin
            if (n_wr < 16) begin
                wa[n_wr] <= o_dmem_waddr;
                wd[n_wr] <= o_dmem_wdata;
            end
            last_wsize <= o_dmem_wsize;
            n_wr <= n_wr + 1;
        end
        if (o_wr) begin
            last_tx_byte <= o_wdata;
            last_tx_cyc <= cyc;
            n_tx <= n_tx + 1;
        end
        if ((!o_dmem_wr && (o_dmem_waddr != 0 || o_dmem_wdata != 0 || o_dmem_wsize != 0)) ||
            (!o_wr && (o_tx_start || o_wdata != 0)) || (o_wr != o_tx_start) ||
            (o_rd && !i_rx_done))
            bad <= bad + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                repeat (tx_delay) @(posedge clk);
                #1 i_tx_done = 1'b1;
                @(posedge clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit popped = 0;
        i_rx_done = 1'b0;
        step(gap);
        i_rx_done = 1'b1;
        i_rx_data = b;
        for (int i = 0; i < 64 && !popped; i++) begin
            @(negedge clk);
            popped = o_rd;
            if (popped) last_pop_cyc = cyc;
            @(posedge clk);
            #1;
        end
        i_rx_done = 1'b0;
        if (!popped) check("pop_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps ? gseq % 6 : 0);
            gseq++;
        end
    endtask

    task automatic wait_for(input string tag, input int which, input int target);
        int v = 0;
        for (int i = 0; i < 100; i++) begin
            v = (which == 0) ? n_tx : n_done;
            if (v >= target) break;
            step(1);
        end
        check(tag, 32'(v), 32'(target));
    endtask

    initial begin
        int rd0, wr0, tx0, dn0;
        #2;
        check("rst_wr", {31'b0, o_dmem_wr}, 32'd0);
        check("rst_outs", {28'b0, o_rd, o_wr, o_done, o_tx_start}, 32'd0);
        step(2);
        i_rst_n = 1'b1;
        i_rx_done = 1'b1;
        i_rx_data = 8'h55;
        step(5);
        i_rx_done = 1'b0;
        check("idle_no_pop", 32'(n_rd), 32'd0);

        // basic frame then terminator
        pulse_start();
        send_word(32'h0000_0010, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_for("tx1", 0, 1);
        check("w1_cnt", 32'(n_wr), 32'd1);
        check("w1_addr", wa[0], 32'h0000_0010);
        check("w1_data", wd[0], 32'hDEAD_BEEF);
        check("w1_size", {30'b0, last_wsize}, 32'd3);
        check("ack_byte", {24'b0, last_tx_byte}, 32'hA5);
        check("rd_8", 32'(n_rd), 32'd8);
        send_word(32'hFFFF_FFFF, 0);
        wait_for("term1", 1, 1);
        step(3);
        check("term1_wr", 32'(n_wr), 32'd1);

        // terminator-only session
        pulse_start();
        rd0 = n_rd;
        send_word(32'hFFFF_FFFF, 0);
        wait_for("term2", 1, 2);
        step(4);
        check("term2_once", 32'(n_done), 32'd2);
        check("term2_nowr", 32'(n_wr), 32'd1);
        check("term2_notx", 32'(n_tx), 32'd1);
        i_rx_done = 1'b1;
        step(4);
        i_rx_done = 1'b0;
        check("term2_idle", 32'(n_rd - rd0), 32'd4);

        // gapped delivery, all-ones data word
        pulse_start();
        rd0 = n_rd;
        send_word(32'h0000_0010, 1);
        send_word(32'hDEAD_BEEF, 1);
        wait_for("tx2", 0, 2);
        check("gap_addr", wa[1], 32'h0000_0010);
        check("gap_data", wd[1], 32'hDEAD_BEEF);
        check("gap_rd", 32'(n_rd - rd0), 32'd8);
        step(2);
        send_word(32'h0000_0020, 1);
        send_word(32'hFFFF_FFFF, 1);
        wait_for("tx3", 0, 3);
        check("ones_addr", wa[2], 32'h0000_0020);
        check("ones_data", wd[2], 32'hFFFF_FFFF);
        step(2);
        send_word(32'hFFFF_FFFF, 0);
        wait_for("term3", 1, 3);

        // two transactions, slow Tx on the first ACK
        tx_delay = 20;
        pulse_start();
        send_word(32'h0000_0004, 0);
        send_word(32'h0000_0001, 0);
        wait_for("tx4", 0, 4);
        tx_delay = 2;
        send_byte(8'h08, 0);
        check("ack_hold", 32'(last_pop_cyc - last_tx_cyc), 32'd21);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'h0000_0002, 0);
        wait_for("tx5", 0, 5);
        step(2);
        send_word(32'hFFFF_FFFF, 0);
        wait_for("term4", 1, 4);
        check("two_a0", wa[3], 32'h0000_0004);
        check("two_d0", wd[3], 32'h0000_0001);
        check("two_a1", wa[4], 32'h0000_0008);
        check("two_d1", wd[4], 32'h0000_0002);
        check("two_wr", 32'(n_wr), 32'd5);

        // reset after two address bytes
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #3 i_rst_n = 1'b0;
        #1 check("rst_mid", {28'b0, o_rd, o_wr, o_done, o_dmem_wr}, 32'd0);
        step(2);
        i_rst_n = 1'b1;
        step(1);
        pulse_start();
        send_word(32'h0000_0100, 0);
        send_word(32'h1234_5678, 0);
        wait_for("tx6", 0, 6);
        check("rst_addr", wa[5], 32'h0000_0100);
        check("rst_data", wd[5], 32'h1234_5678);

        // reset while waiting in ACK, then no activity until start
        tx_delay = 30;
        step(2);
        send_word(32'h0000_0200, 0);
        send_word(32'h0000_0003, 0);
        wait_for("tx7", 0, 7);
        step(3);
        i_rst_n = 1'b0;
        step(1);
        i_rst_n = 1'b1;
        rd0 = n_rd;
        wr0 = n_wr;
        tx0 = n_tx;
        i_rx_done = 1'b1;
        step(40);
        i_rx_done = 1'b0;
        check("ackrst_rd", 32'(n_rd - rd0), 32'd0);
        check("ackrst_wr", 32'(n_wr - wr0 + n_tx - tx0), 32'd0);
        tx_delay = 5;

        // start pulses mid-frame and mid-ACK are ignored
        pulse_start();
        rd0 = n_rd;
        dn0 = n_done;
        send_word(32'h0000_0300, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        pulse_start();
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        wait_for("tx8", 0, 8);
        pulse_start();
        send_word(32'h0000_0304, 0);
        send_word(32'h0000_0009, 0);
        wait_for("tx9", 0, 9);
        check("st_a0", wa[7], 32'h0000_0300);
        check("st_d0", wd[7], 32'h1122_3344);
        check("st_a1", wa[8], 32'h0000_0304);
        check("st_d1", wd[8], 32'h0000_0009);
        check("st_rd", 32'(n_rd - rd0), 32'd16);
        step(2);
        send_word(32'hFFFF_FFFF, 0);
        wait_for("term5", 1, dn0 + 1);
        check("clean_outputs", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
